// File: rtl/freq_meter.sv
// Frequency meter: hysteretic level crossing, period averaging and serial divide to Hz.
// Optional FREQ_METER_HYST_EN enables the +/-HYST threshold band; without it the compare is strict.
module freq_meter #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned MEAN_W      = 14,
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned HYST        = 16,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [MEAN_W-1:0] mean,
    output logic [31:0]       freq_out,
    output logic              freq_valid,
    output logic              no_signal
);

    localparam int unsigned CMP_W    = ((DATA_W > MEAN_W) ? DATA_W : MEAN_W) + 1;
    localparam int unsigned NPER     = 1 << AVG_LOG2;
    localparam int unsigned NPER_W   = 5;
    localparam int unsigned ITER_W   = 6;
`ifdef FREQ_METER_HYST_EN
    localparam int unsigned HYST_EFF = HYST;
`else
    // Band collapsed to zero width: strict data<mean / data>mean compares.
    localparam int unsigned HYST_EFF = HYST * 0;
`endif
    localparam logic [CMP_W-1:0] HYST_V   = CMP_W'(HYST_EFF);
    localparam logic [CMP_W-1:0] MEAN_MAX = CMP_W'({MEAN_W{1'b1}});
    localparam logic [31:0]      DIVIDEND = 32'(CLK_HZ << AVG_LOG2);

    typedef enum logic {
        WAIT_LOW  = 1'b0,
        WAIT_HIGH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CMP_W-1:0]    data_x, mean_x, lo_th, hi_th, hi_sum;
    logic                low_c, high_c, rise_c, timeout_c, batch_c;
    logic [31:0]         cnt_q, acc_q, sum_c;
    logic [NPER_W-1:0]   nper_q;
    logic                first_q;
    logic                busy_q;
    logic [ITER_W-1:0]   iter_q;
    logic [31:0]         div_q, quo_q, rem_q;
    logic [32:0]         rem_sh_c;
    logic                rem_ge_c;

    // Threshold compare on zero-extended operands; zero-width band means strict compare.
    always_comb begin
        data_x = CMP_W'(data);
        mean_x = CMP_W'(mean);
        lo_th  = (mean_x > HYST_V) ? (mean_x - HYST_V) : '0;
        hi_sum = mean_x + HYST_V;
        hi_th  = (hi_sum > MEAN_MAX) ? MEAN_MAX : hi_sum;
        if (HYST_EFF == 0) begin
            low_c  = (data_x < mean_x);
            high_c = (data_x > mean_x);
        end else begin
            low_c  = (data_x <= lo_th);
            high_c = (data_x >= hi_th);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= WAIT_LOW;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = WAIT_LOW;
        end else begin
            case (state_q)
                WAIT_LOW:  if (low_c)  state_d = WAIT_HIGH;
                WAIT_HIGH: if (high_c) state_d = WAIT_LOW;
                default:   state_d = WAIT_LOW;
            endcase
        end
    end

    // Event decode: timeout outranks a coincident rising event.
    always_comb begin
        timeout_c = (cnt_q == 32'(TIMEOUT_CYC));
        rise_c    = (state_q == WAIT_HIGH) && high_c && !timeout_c;
        batch_c   = rise_c && !first_q && (nper_q == NPER_W'(NPER - 1));
        sum_c     = acc_q + cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            nper_q    <= '0;
            first_q   <= 1'b1;
            no_signal <= 1'b0;
        end else if (timeout_c) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            nper_q    <= '0;
            first_q   <= 1'b1;
            no_signal <= 1'b1;
        end else if (rise_c) begin
            cnt_q     <= 32'd1;
            first_q   <= 1'b0;
            no_signal <= 1'b0;
            if (!first_q) begin
                if (batch_c) begin
                    acc_q  <= '0;
                    nper_q <= '0;
                end else begin
                    acc_q  <= sum_c;
                    nper_q <= nper_q + NPER_W'(1);
                end
            end
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // One restoring-divide step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh_c = {rem_q, quo_q[31]};
        rem_ge_c = (rem_sh_c >= {1'b0, div_q});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            iter_q     <= '0;
            div_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (timeout_c) begin
                busy_q   <= 1'b0;
                freq_out <= '0;
            end else if (busy_q) begin
                if (iter_q == ITER_W'(32)) begin
                    busy_q     <= 1'b0;
                    freq_out   <= quo_q;
                    freq_valid <= 1'b1;
                end else begin
                    rem_q  <= rem_ge_c ? 32'(rem_sh_c - {1'b0, div_q}) : rem_sh_c[31:0];
                    quo_q  <= {quo_q[30:0], rem_ge_c};
                    iter_q <= iter_q + ITER_W'(1);
                end
            end else if (batch_c) begin
                busy_q <= 1'b1;
                iter_q <= '0;
                div_q  <= sum_c;
                quo_q  <= DIVIDEND;
                rem_q  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (4-period and 1-period averaging) against an
// event-timestamp reference model; honours FREQ_METER_HYST_EN when defined.
module tb_freq_meter;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned MEAN_W = 14;
    localparam int unsigned CLK_HZ = 50000000;
    localparam int unsigned HYST   = 16;
    localparam int unsigned TMO    = 4000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic [MEAN_W-1:0] mean = 14'd2048;
    logic [31:0]       fo [2];
    logic              fv [2];
    logic              ns [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    freq_meter #(.DATA_W(DATA_W), .MEAN_W(MEAN_W), .CLK_HZ(CLK_HZ), .AVG_LOG2(2),
                 .HYST(HYST), .TIMEOUT_CYC(TMO)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data(data), .mean(mean),
        .freq_out(fo[0]), .freq_valid(fv[0]), .no_signal(ns[0]));

    freq_meter #(.DATA_W(DATA_W), .MEAN_W(MEAN_W), .CLK_HZ(CLK_HZ), .AVG_LOG2(0),
                 .HYST(HYST), .TIMEOUT_CYC(TMO)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data(data), .mean(mean),
        .freq_out(fo[1]), .freq_valid(fv[1]), .no_signal(ns[1]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: tracks rising events by clock-edge index; a period is the
    // edge distance between consecutive events, silence is measured the same way.
    longint      t = 0;
    int unsigned avg_log2 [2] = '{2, 0};
    bit          armed [2];
    bit          first [2];
    bit          busy [2];
    longint      anchor [2];
    longint      last_ev [2];
    longint      due [2];
    longint      res [2];
    longint      per_q [2][$];
    logic [31:0] m_freq [2];
    bit          m_valid [2];
    bit          m_ns [2];

    function automatic bit is_low(input int d, input int m);
`ifdef FREQ_METER_HYST_EN
        if (HYST == 0) return d < m;
        return d <= ((m > int'(HYST)) ? m - int'(HYST) : 0);
`else
        return d < m;
`endif
    endfunction

    function automatic bit is_high(input int d, input int m);
`ifdef FREQ_METER_HYST_EN
        int top;
        top = (1 << MEAN_W) - 1;
        if (HYST == 0) return d > m;
        return d >= ((m + int'(HYST) > top) ? top : m + int'(HYST));
`else
        return d > m;
`endif
    endfunction

    task automatic model_step(input int i);
        bit     busy_pre;
        longint sum;
        busy_pre   = busy[i];
        m_valid[i] = 1'b0;
        if (!rst_n) begin
            armed[i] = 0; first[i] = 1; busy[i] = 0; anchor[i] = t + 1;
            per_q[i].delete(); m_freq[i] = '0; m_ns[i] = 0;
            return;
        end
        if (t - anchor[i] == longint'(TMO)) begin
            m_freq[i] = '0; m_ns[i] = 1; busy[i] = 0; per_q[i].delete();
            first[i] = 1; armed[i] = 0; anchor[i] = t + 1;
            return;
        end
        if (!armed[i] && is_low(int'(data), int'(mean))) begin
            armed[i] = 1;
        end else if (armed[i] && is_high(int'(data), int'(mean))) begin
            armed[i] = 0;
            m_ns[i]  = 0;
            if (!first[i]) begin
                per_q[i].push_back(t - last_ev[i]);
                if (per_q[i].size() == (1 << avg_log2[i])) begin
                    sum = 0;
                    foreach (per_q[i][k]) sum += per_q[i][k];
                    per_q[i].delete();
                    if (!busy_pre) begin
                        busy[i] = 1;
                        due[i]  = t + 33;
                        res[i]  = (longint'(CLK_HZ) << avg_log2[i]) / sum;
                    end
                end
            end
            first[i] = 0; last_ev[i] = t; anchor[i] = t;
        end
        if (busy_pre && t == due[i]) begin
            m_freq[i] = 32'(res[i]); m_valid[i] = 1; busy[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        t++;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // Per-cycle scoreboard: compare whenever either side shows activity or a change.
    bit          chk_en = 0;
    int          pulses [2] = '{0, 0};
    logic [31:0] prev_fo [2] = '{0, 0};
    logic [31:0] prev_mf [2] = '{0, 0};
    bit          prev_ns [2] = '{0, 0};
    bit          prev_mn [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fv[i]) pulses[i]++;
            if (chk_en) begin
                if (fv[i] || m_valid[i])
                    check($sformatf("u%0d freq_valid@%0d", i, t), 64'(fv[i]), 64'(m_valid[i]));
                if (fo[i] != prev_fo[i] || m_freq[i] != prev_mf[i])
                    check($sformatf("u%0d freq_out@%0d", i, t), 64'(fo[i]), 64'(m_freq[i]));
                if (ns[i] != prev_ns[i] || m_ns[i] != prev_mn[i])
                    check($sformatf("u%0d no_signal@%0d", i, t), 64'(ns[i]), 64'(m_ns[i]));
            end
            prev_fo[i] = fo[i]; prev_mf[i] = m_freq[i];
            prev_ns[i] = ns[i]; prev_mn[i] = m_ns[i];
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic square(input int lo_v, input int hi_v, input int half, input int n);
        for (int k = 0; k < n; k++) begin
            data = DATA_W'(lo_v); cycles(half);
            data = DATA_W'(hi_v); cycles(half);
        end
    endtask

    int p0, p1;

    initial begin
        @(negedge clk);
        rst_n = 1'b0; data = '0; mean = 14'd2048;
        cycles(5);
        chk_en = 1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d reset freq_out", i), 64'(fo[i]), 64'd0);
            check($sformatf("u%0d reset freq_valid", i), 64'(fv[i]), 64'd0);
            check($sformatf("u%0d reset no_signal", i), 64'(ns[i]), 64'd0);
        end
        rst_n = 1'b1;

        // 1000-cycle square wave, then 500-cycle
        square(0, 4095, 500, 6);
        check("u0 period1000", 64'(fo[0]), 64'd50000);
        check("u1 period1000", 64'(fo[1]), 64'd50000);
        square(0, 4095, 250, 6);
        check("u1 period500", 64'(fo[1]), 64'd100000);

        // Noise around the mean: frequent events, batches dropped while dividing
        for (int k = 0; k < 2000; k++) begin
            data = DATA_W'($urandom_range(0, 4095));
            cycles(1);
        end

        // Random square waves with random levels and centre
        for (int r = 0; r < 6; r++) begin
            mean = MEAN_W'($urandom_range(1800, 2300));
            square($urandom_range(0, 1500), $urandom_range(2600, 4095),
                   $urandom_range(20, 300), 4);
        end

        // Small swing inside the hysteresis band, then a swing outside it
        mean = 14'd2048;
        p1 = pulses[1];
        square(2040, 2056, 50, 10);
`ifdef FREQ_METER_HYST_EN
        check("hyst band no pulses", 64'(pulses[1] - p1), 64'd0);
`else
        check("strict band pulses", 64'(pulses[1] - p1 > 0), 64'd1);
`endif
        p1 = pulses[1];
        square(2000, 2100, 50, 10);
        check("wide swing pulses", 64'(pulses[1] - p1 > 0), 64'd1);

        // Loss of signal after a valid result, then recovery
        square(0, 4095, 500, 6);
        data = 12'd4095;
        cycles(TMO + 50);
        check("u0 timeout no_signal", 64'(ns[0]), 64'd1);
        check("u0 timeout freq_out", 64'(fo[0]), 64'd0);
        check("u1 timeout no_signal", 64'(ns[1]), 64'd1);
        p0 = pulses[0];
        square(0, 4095, 500, 2);
        check("u0 two events no pulse", 64'(pulses[0] - p0), 64'd0);
        check("u0 no_signal cleared", 64'(ns[0]), 64'd0);
        square(0, 4095, 500, 4);
        check("u0 recovered freq", 64'(fo[0]), 64'd50000);

        // Reset 10 cycles into a divide
        rst_n = 1'b0; cycles(2); rst_n = 1'b1;
        square(0, 4095, 500, 4);
        data = '0; cycles(500);
        p0 = pulses[0];
        data = 12'd4095; cycles(10);
        rst_n = 1'b0; cycles(3);
        check("u0 reset mid-divide freq_out", 64'(fo[0]), 64'd0);
        check("u0 reset mid-divide no_signal", 64'(ns[0]), 64'd0);
        rst_n = 1'b1;
        cycles(40);
        check("u0 no pulse after abort", 64'(pulses[0] - p0), 64'd0);

        // Threshold clamps: small mean arms on data=0; full-scale mean never fires
        mean = 14'd8;
        square(0, 100, 50, 6);
        check("u0 mean8 freq", 64'(fo[0]), 64'd500000);
        check("u1 mean8 freq", 64'(fo[1]), 64'd500000);
        mean = 14'd16383;
        p0 = pulses[0]; p1 = pulses[1];
        square(0, 4095, 100, 5);
        check("mean max no pulses", 64'(pulses[0] - p0 + pulses[1] - p1), 64'd0);

        cycles(50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
